muldiv_sequencer: RTL and testbench

- Multi-cycle controller that shares the external multiply/divide unit with the single-cycle datapath.
- Detects R-type mul/div instructions and freezes the PC and normal register writeback.
- Issues one start pulse to the mul/div unit, waits for its ready flag, then drives a dedicated one-cycle writeback of the result, or of the exception code to $rstatus.
- Sits beside the instruction decoder; its stall output gates PC update and the decoder's register write enable.

---
 rtl/muldiv_sequencer.sv | 151 +++++++++++++++
 tb/tb_muldiv_sequencer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - mul/div sequencer: stalls the pipeline, starts the shared unit, writes back the result.
// Optional MULDIV_TIMEOUT_EN adds a WAIT watchdog that forces an exception writeback.
module muldiv_sequencer #(
`ifdef MULDIV_TIMEOUT_EN
  parameter int unsigned TIMEOUT      = 40,
`endif
  parameter logic [4:0]  MUL_ALUOP    = 5'b00110,
  parameter logic [4:0]  DIV_ALUOP    = 5'b00111,
  parameter logic [4:0]  RSTATUS_REG  = 5'd30,
  parameter logic [31:0] MUL_EXC_CODE = 32'd4,
  parameter logic [31:0] DIV_EXC_CODE = 32'd5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  opcode,
  input  logic [4:0]  alu_op,
  input  logic [4:0]  rd,
  input  logic        md_ready,
  input  logic        md_exception,
  input  logic [31:0] md_result,
  output logic        ctrl_mult,
  output logic        ctrl_div,
  output logic        stall,
  output logic        busy,
  output logic        wb_en,
  output logic [4:0]  wb_reg,
  output logic [31:0] wb_data
);

  typedef enum logic [1:0] {IDLE, START, WAIT, WB} state_t;

  state_t      state_q, state_d;
  logic        kind_div_q, kind_div_d;
  logic [4:0]  rd_q, rd_d;
  logic [4:0]  wb_reg_q, wb_reg_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        ctrl_mult_q, ctrl_mult_d;
  logic        ctrl_div_q, ctrl_div_d;
  logic        busy_q, busy_d;
  logic        wb_en_q, wb_en_d;
  logic        stall_c;
  logic        is_md;
  logic [31:0] exc_code;

`ifdef MULDIV_TIMEOUT_EN
  localparam logic [5:0] WDOG_LAST = 6'(TIMEOUT - 1);
  logic [5:0] wdog_q, wdog_d;
`endif

  assign is_md    = (opcode == 5'd0) && ((alu_op == MUL_ALUOP) || (alu_op == DIV_ALUOP));
  assign exc_code = kind_div_q ? DIV_EXC_CODE : MUL_EXC_CODE;

  always_comb begin
    state_d    = state_q;
    kind_div_d = kind_div_q;
    rd_d       = rd_q;
    wb_reg_d   = wb_reg_q;
    wb_data_d  = wb_data_q;
    stall_c    = 1'b0;
`ifdef MULDIV_TIMEOUT_EN
    wdog_d     = wdog_q;
`endif
    case (state_q)
      IDLE: begin
        stall_c = is_md;
        if (is_md) begin
          rd_d       = rd;
          kind_div_d = (alu_op == DIV_ALUOP);
          state_d    = START;
        end
      end
      START: begin
        stall_c = 1'b1;
        state_d = WAIT;
`ifdef MULDIV_TIMEOUT_EN
        wdog_d  = 6'd0;
`endif
      end
      WAIT: begin
        stall_c = 1'b1;
        if (md_ready) begin
          state_d = WB;
          if (md_exception) begin
            wb_reg_d  = RSTATUS_REG;
            wb_data_d = exc_code;
          end else begin
            wb_reg_d  = rd_q;
            wb_data_d = md_result;
          end
        end
`ifdef MULDIV_TIMEOUT_EN
        // A late ready in the limit cycle still wins over the watchdog.
        else if (wdog_q == WDOG_LAST) begin
          state_d   = WB;
          wb_reg_d  = RSTATUS_REG;
          wb_data_d = exc_code;
        end else begin
          wdog_d = wdog_q + 6'd1;
        end
`endif
      end
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Strobes are decoded from the next state so they come straight off flops.
    ctrl_mult_d = (state_d == START) && !kind_div_d;
    ctrl_div_d  = (state_d == START) && kind_div_d;
    busy_d      = (state_d == START) || (state_d == WAIT);
    wb_en_d     = (state_d == WB) && (wb_reg_d != 5'd0);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      kind_div_q  <= 1'b0;
      rd_q        <= 5'd0;
      wb_reg_q    <= 5'd0;
      wb_data_q   <= 32'd0;
      ctrl_mult_q <= 1'b0;
      ctrl_div_q  <= 1'b0;
      busy_q      <= 1'b0;
      wb_en_q     <= 1'b0;
`ifdef MULDIV_TIMEOUT_EN
      wdog_q      <= 6'd0;
`endif
    end else begin
      state_q     <= state_d;
      kind_div_q  <= kind_div_d;
      rd_q        <= rd_d;
      wb_reg_q    <= wb_reg_d;
      wb_data_q   <= wb_data_d;
      ctrl_mult_q <= ctrl_mult_d;
      ctrl_div_q  <= ctrl_div_d;
      busy_q      <= busy_d;
      wb_en_q     <= wb_en_d;
`ifdef MULDIV_TIMEOUT_EN
      wdog_q      <= wdog_d;
`endif
    end
  end

  assign stall     = reset & stall_c;
  assign ctrl_mult = ctrl_mult_q;
  assign ctrl_div  = ctrl_div_q;
  assign busy      = busy_q;
  assign wb_en     = wb_en_q;
  assign wb_reg    = wb_reg_q;
  assign wb_data   = wb_data_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - random and directed bench for muldiv_sequencer against a timeline model.
module tb_muldiv_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  opcode, alu_op, rd;
  logic        md_ready, md_exception;
  logic [31:0] md_result;
  logic        ctrl_mult, ctrl_div, stall, busy, wb_en;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;

  int checks = 0;
  int errors = 0;

  muldiv_sequencer dut (
    .clock(clock), .reset(reset), .opcode(opcode), .alu_op(alu_op), .rd(rd),
    .md_ready(md_ready), .md_exception(md_exception), .md_result(md_result),
    .ctrl_mult(ctrl_mult), .ctrl_div(ctrl_div), .stall(stall), .busy(busy),
    .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_md_f(input logic [4:0] op, input logic [4:0] alu);
    return (op == 5'd0) && ((alu == 5'd6) || (alu == 5'd7));
  endfunction

  // Model: an in-flight instruction is tracked by its age in cycles since detection.
  // age 1 is the start cycle, age >= 2 is waiting; m_wb marks the single writeback cycle.
`ifdef MULDIV_TIMEOUT_EN
  localparam int TO = 40;
`endif
  bit          m_active = 1'b0, m_wb = 1'b0, m_div = 1'b0;
  int          m_age = 0;
  logic [4:0]  m_rd = 5'd0, m_reg = 5'd0;
  logic [31:0] m_data = 32'd0;

  always @(posedge clock) begin
    if (!reset) begin
      m_active = 1'b0; m_wb = 1'b0; m_age = 0; m_reg = 5'd0; m_data = 32'd0;
    end else if (m_wb) begin
      m_wb = 1'b0; m_active = 1'b0;
    end else if (m_active) begin
      if (m_age >= 2 && md_ready) begin
        m_wb = 1'b1;
        if (md_exception) begin m_reg = 5'd30; m_data = m_div ? 32'd5 : 32'd4; end
        else begin m_reg = m_rd; m_data = md_result; end
      end
`ifdef MULDIV_TIMEOUT_EN
      else if (m_age >= 2 && (m_age - 1) == TO) begin
        m_wb = 1'b1; m_reg = 5'd30; m_data = m_div ? 32'd5 : 32'd4;
      end
`endif
      m_age++;
    end else if (is_md_f(opcode, alu_op)) begin
      m_active = 1'b1; m_age = 1; m_rd = rd; m_div = (alu_op == 5'd7);
    end
  end

  always @(negedge clock) begin
    if (!reset) begin
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_mult", 32'(ctrl_mult), 32'd0);
      chk("rst_div", 32'(ctrl_div), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_wb_en", 32'(wb_en), 32'd0);
      chk("rst_wb_reg", 32'(wb_reg), 32'd0);
      chk("rst_wb_data", wb_data, 32'd0);
    end else begin
      chk("m_stall", 32'(stall),
          32'(m_wb ? 1'b0 : (m_active ? 1'b1 : is_md_f(opcode, alu_op))));
      chk("m_mult", 32'(ctrl_mult), 32'(m_active && !m_wb && m_age == 1 && !m_div));
      chk("m_div", 32'(ctrl_div), 32'(m_active && !m_wb && m_age == 1 && m_div));
      chk("m_busy", 32'(busy), 32'(m_active && !m_wb));
      chk("m_wb_en", 32'(wb_en), 32'(m_wb && m_reg != 5'd0));
      chk("m_wb_reg", 32'(wb_reg), 32'(m_reg));
      chk("m_wb_data", wb_data, m_data);
    end
  end

  task automatic run_md(input logic is_div, input logic [4:0] rd_v, input int ready_idx,
                        input logic exc, input logic [31:0] res, input int exp_wb_idx,
                        input logic [4:0] exp_reg, input logic [31:0] exp_data,
                        input logic exp_en, input int busy_idx, input int max_n);
    int mults = 0, divs = 0, wb_idx = -1;
    opcode = 5'd0; alu_op = is_div ? 5'd7 : 5'd6; rd = rd_v;
    for (int n = 0; n < max_n && wb_idx < 0; n++) begin
      md_ready = (n == ready_idx); md_exception = exc && (n == ready_idx); md_result = res;
      @(negedge clock);
      mults += int'(ctrl_mult); divs += int'(ctrl_div);
      if (n == busy_idx) begin
        chk("long_wait_busy", 32'(busy), 32'd1);
        chk("long_wait_stall", 32'(stall), 32'd1);
      end
      if (n > 0 && !stall && wb_idx < 0) begin
        wb_idx = n;
        chk("d_wb_reg", 32'(wb_reg), 32'(exp_reg));
        chk("d_wb_data", wb_data, exp_data);
        chk("d_wb_en", 32'(wb_en), 32'(exp_en));
      end
      @(posedge clock); #1;
    end
    chk("d_wb_index", wb_idx, exp_wb_idx);
    chk("d_mult_pulses", mults, is_div ? 0 : 1);
    chk("d_div_pulses", divs, is_div ? 1 : 0);
    opcode = 5'd1; md_ready = 1'b0; md_exception = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    reset = 1'b0; opcode = 5'd0; alu_op = 5'd6; rd = 5'd0;
    md_ready = 1'b0; md_exception = 1'b0; md_result = 32'd0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("reset_stall", 32'(stall), 32'd0);
    chk("reset_wb_data", wb_data, 32'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    chk("release_stall", 32'(stall), 32'd1);
    @(posedge clock); #1;
    opcode = 5'd1; md_ready = 1'b1;
    repeat (6) @(posedge clock);
    #1 md_ready = 1'b0;

    // mul r7, ready three cycles after start: writeback at index 5 (6 cycles total)
    run_md(1'b0, 5'd7, 4, 1'b0, 32'h15, 5, 5'd7, 32'h15, 1'b1, -1, 20);
    // div r9, exception in the first wait cycle: 4-cycle latency to $rstatus
    run_md(1'b1, 5'd9, 2, 1'b1, 32'hdead_beef, 3, 5'd30, 32'd5, 1'b1, -1, 20);
    // mul r0: sequence runs but the write is suppressed
    r = $urandom;
    run_md(1'b0, 5'd0, 3, 1'b0, r, 4, 5'd0, r, 1'b0, -1, 20);

    opcode = 5'd0; alu_op = 5'd0; rd = 5'd5;
    repeat (3) begin
      @(negedge clock);
      chk("add_stall", 32'(stall), 32'd0);
      chk("add_mult", 32'(ctrl_mult), 32'd0);
      chk("add_div", 32'(ctrl_div), 32'd0);
      @(posedge clock); #1;
    end

    // reset in the second wait cycle discards the pending result
    opcode = 5'd0; alu_op = 5'd6; rd = 5'd11;
    repeat (3) begin @(posedge clock); #1; end
    reset = 1'b0;
    #1;
    chk("async_stall", 32'(stall), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_wb_en", 32'(wb_en), 32'd0);
    @(posedge clock); #1;
    reset = 1'b1; opcode = 5'd1; md_ready = 1'b1; md_result = 32'h1234;
    repeat (3) begin
      @(negedge clock);
      chk("post_rst_wb_en", 32'(wb_en), 32'd0);
      chk("post_rst_busy", 32'(busy), 32'd0);
      @(posedge clock); #1;
    end
    md_ready = 1'b0;

`ifdef MULDIV_TIMEOUT_EN
    run_md(1'b0, 5'd3, 1000, 1'b0, 32'h77, 42, 5'd30, 32'd4, 1'b1, -1, 60);
`else
    run_md(1'b0, 5'd3, 102, 1'b0, 32'h77, 103, 5'd3, 32'h77, 1'b1, 101, 110);
`endif

    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 199) != 0);
      opcode = ($urandom_range(0, 1) != 0) ? 5'd0 : 5'($urandom_range(0, 31));
      case ($urandom_range(0, 3))
        0: alu_op = 5'd6;
        1: alu_op = 5'd7;
        2: alu_op = 5'd0;
        default: alu_op = 5'($urandom_range(0, 31));
      endcase
      rd = 5'($urandom_range(0, 31));
      md_ready = ($urandom_range(0, 3) == 0);
      md_exception = ($urandom_range(0, 3) == 0);
      md_result = $urandom;
      @(posedge clock); #1;
    end

    reset = 1'b1; opcode = 5'd1; md_ready = 1'b1;
    repeat (5) @(posedge clock);
    @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
